// File: rtl/debug_control_dump.sv
// Debug dump controller: reads words from a source memory on request and streams
// each word out as NB_LATCH-bit frames, MSB first, over a valid/ready frame interface.
module debug_control_dump #(
  parameter int         NB_LATCH         = 8,
  parameter int         NB_INPUT_SIZE    = 32,
  parameter int         NB_CONTROL_FRAME = 32,
  parameter int         NB_ADDR          = 5,
  parameter int         DEPTH            = 32,
  parameter logic [5:0] CONTROLLER_ID    = 6'b000000
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic                        i_request_valid,
  input  logic [5:0]                  i_request_select,
  input  logic                        i_request_mode,
  input  logic [NB_ADDR-1:0]          i_request_addr,
  input  logic [NB_INPUT_SIZE-1:0]    i_data_from_mips,
  input  logic                        i_frame_ready,
  output logic [NB_CONTROL_FRAME-1:0] o_frame_to_interface,
  output logic                        o_frame_valid,
  output logic [NB_ADDR-1:0]          o_addr,
  output logic                        o_reading,
  output logic                        o_busy,
  output logic                        o_done,
  output logic [2:0]                  o_state
);

  localparam int N_FRAMES  = (NB_INPUT_SIZE + NB_LATCH - 1) / NB_LATCH;
  localparam int NB_PADDED = N_FRAMES * NB_LATCH;
  localparam int NB_IDX    = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1;
  localparam logic [NB_IDX-1:0]  LAST_IDX  = NB_IDX'(N_FRAMES - 1);
  localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_LATCH = 3'd2,
    S_SEND  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [NB_ADDR-1:0]    addr_q, addr_d;
  logic                  mode_q, mode_d;
  logic [NB_IDX-1:0]     idx_q, idx_d;
  logic [NB_PADDED-1:0]  shift_q, shift_d;
  logic [NB_PADDED-1:0]  data_padded;
  logic                  accept;
  logic                  transfer;

  // Source word left-aligned so zero padding lands at the LSB end.
  always_comb begin
    data_padded = '0;
    data_padded[NB_PADDED-1 -: NB_INPUT_SIZE] = i_data_from_mips;
  end

  // Handshake: a frame moves on any rising edge where o_frame_valid and
  // i_frame_ready are both high; frame and valid hold until then.
  assign accept   = i_request_valid && (i_request_select == CONTROLLER_ID);
  assign transfer = (state_q == S_SEND) && i_frame_ready;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      mode_q  <= 1'b0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    mode_d  = mode_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_ADDR;
          mode_d  = i_request_mode;
          addr_d  = i_request_mode ? '0 : i_request_addr;
        end
      end
      S_ADDR:  state_d = S_LATCH;
      S_LATCH: begin
        shift_d = data_padded;
        idx_d   = '0;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (transfer) begin
          if (idx_q != LAST_IDX) begin
            idx_d   = idx_q + 1'b1;
            shift_d = shift_q << NB_LATCH;
          end else if (!mode_q || (addr_q == LAST_ADDR)) begin
            // Full dump stops at DEPTH-1; the counter never wraps.
            state_d = S_DONE;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = S_ADDR;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_frame_to_interface = '0;
    if (state_q == S_SEND) begin
      o_frame_to_interface[NB_LATCH-1:0] = shift_q[NB_PADDED-1 -: NB_LATCH];
    end
  end

  assign o_frame_valid = (state_q == S_SEND);
  assign o_addr        = addr_q;
  assign o_reading     = (state_q == S_ADDR) || (state_q == S_LATCH);
  assign o_busy        = (state_q != S_IDLE);
  assign o_done        = (state_q == S_DONE);
  assign o_state       = state_q;

endmodule

// File: tb/tb_debug_control_dump.sv
// Directed bench for debug_control_dump: a 32/8 instance with DEPTH=4 and a 12/8
// instance, driven from a registered source-memory model and an expected-frame queue.
module tb_debug_control_dump;

  localparam logic [5:0] ID = 6'b000000;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid_a, req_valid_b;
  logic [5:0]  req_sel;
  logic        req_mode;
  logic [4:0]  req_addr;
  logic        ready;

  logic [31:0] data_a;
  logic [31:0] frame_a;
  logic        fvalid_a, reading_a, busy_a, done_a;
  logic [4:0]  addr_a;
  logic [2:0]  state_a;

  logic [11:0] data_b;
  logic [31:0] frame_b;
  logic        fvalid_b, reading_b, busy_b, done_b;
  logic [4:0]  addr_b;
  logic [2:0]  state_b;

  logic [31:0] mem_a [32];
  logic [31:0] exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          span;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Source memory: data is valid one cycle after the address.
  always @(posedge clk) data_a <= mem_a[addr_a];
  assign data_b = 12'hABC;

  debug_control_dump #(
    .NB_LATCH(8), .NB_INPUT_SIZE(32), .NB_CONTROL_FRAME(32),
    .NB_ADDR(5), .DEPTH(4), .CONTROLLER_ID(ID)
  ) dut_a (
    .i_clock(clk), .i_reset(reset),
    .i_request_valid(req_valid_a), .i_request_select(req_sel),
    .i_request_mode(req_mode), .i_request_addr(req_addr),
    .i_data_from_mips(data_a), .i_frame_ready(ready),
    .o_frame_to_interface(frame_a), .o_frame_valid(fvalid_a),
    .o_addr(addr_a), .o_reading(reading_a), .o_busy(busy_a),
    .o_done(done_a), .o_state(state_a)
  );

  debug_control_dump #(
    .NB_LATCH(8), .NB_INPUT_SIZE(12), .NB_CONTROL_FRAME(32),
    .NB_ADDR(5), .DEPTH(32), .CONTROLLER_ID(ID)
  ) dut_b (
    .i_clock(clk), .i_reset(reset),
    .i_request_valid(req_valid_b), .i_request_select(req_sel),
    .i_request_mode(req_mode), .i_request_addr(req_addr),
    .i_data_from_mips(data_b), .i_frame_ready(ready),
    .o_frame_to_interface(frame_b), .o_frame_valid(fvalid_b),
    .o_addr(addr_b), .o_reading(reading_b), .o_busy(busy_b),
    .o_done(done_b), .o_state(state_b)
  );

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) exp_q.push_back({24'd0, w[31-8*k -: 8]});
  endtask

  // ---------------- driver tasks ----------------
  // Issues a request at the current negedge and checks the ADDR and LATCH cycles;
  // returns at the negedge of the first frame cycle.
  task automatic start_a(input logic mode, input logic [4:0] addr, input logic poke_busy);
    logic [31:0] first;
    first = mode ? 32'd0 : {27'd0, addr};
    req_sel = ID; req_mode = mode; req_addr = addr; req_valid_a = 1'b1;
    @(negedge clk);
    req_valid_a = poke_busy;
    if (poke_busy) begin
      req_mode = ~mode; req_addr = addr + 5'd1;
    end
    check("addr_stage_addr", {27'd0, addr_a}, first);
    check("addr_stage_reading", {31'd0, reading_a}, 32'd1);
    check("addr_stage_busy", {31'd0, busy_a}, 32'd1);
    check("addr_stage_valid", {31'd0, fvalid_a}, 32'd0);
    @(negedge clk);
    req_valid_a = 1'b0;
    check("latch_stage_addr", {27'd0, addr_a}, first);
    check("latch_stage_reading", {31'd0, reading_a}, 32'd1);
    check("latch_stage_valid", {31'd0, fvalid_a}, 32'd0);
    @(negedge clk);
  endtask

  // Consumes frames until o_done; optionally stalls one frame and pokes a request in DONE.
  task automatic collect_a(input int stall_frame, input int stall_cycles,
                           input logic poke_done, output int done_at);
    int          fidx = 0;
    int          stalled = 0;
    int          cycles = 0;
    logic        holding = 1'b0;
    logic        finished = 1'b0;
    logic [31:0] held = '0;
    logic [31:0] exp;
    done_at = -1;
    while (!finished && cycles < 400) begin
      if (holding) check("hold_frame", frame_a, held);
      holding = 1'b0;
      if (!fvalid_a) check("idle_frame_zero", frame_a, 32'd0);
      req_valid_a = 1'b0;
      if (done_a) begin
        done_at = cycles;
        finished = 1'b1;
        check("done_valid_low", {31'd0, fvalid_a}, 32'd0);
        if (poke_done) begin
          req_sel = ID; req_mode = 1'b1; req_addr = 5'd0; req_valid_a = 1'b1;
        end
      end else if (fvalid_a) begin
        if (fidx == stall_frame && stalled < stall_cycles) begin
          ready = 1'b0; stalled++; held = frame_a; holding = 1'b1;
        end else begin
          ready = 1'b1;
          exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
          check("frame", frame_a, exp);
          fidx++;
        end
      end else begin
        ready = 1'b1;
      end
      @(negedge clk);
      cycles++;
    end
    req_valid_a = 1'b0;
    ready = 1'b1;
    check("done_seen", {31'd0, finished}, 32'd1);
    check("done_one_cycle", {31'd0, done_a}, 32'd0);
    check("idle_after_done", {31'd0, busy_a}, 32'd0);
    check("frames_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_frame"}, frame_a, 32'd0);
    check({tag, "_valid"}, {31'd0, fvalid_a}, 32'd0);
    check({tag, "_addr"}, {27'd0, addr_a}, 32'd0);
    check({tag, "_reading"}, {31'd0, reading_a}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy_a}, 32'd0);
    check({tag, "_done"}, {31'd0, done_a}, 32'd0);
    check({tag, "_state"}, {29'd0, state_a}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 32; i++) mem_a[i] = 32'h5A5A_0000 | i;
    reset = 1'b1; ready = 1'b1;
    req_valid_a = 1'b0; req_valid_b = 1'b0;
    req_sel = ID; req_mode = 1'b0; req_addr = 5'd0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    check("reset_b_busy", {31'd0, busy_b}, 32'd0);
    reset = 1'b0;

    // Single word, address 5 (beyond DEPTH-1, still read); request poked in DONE.
    mem_a[5] = 32'hDEAD_BEEF;
    push_word(32'hDEAD_BEEF);
    start_a(1'b0, 5'd5, 1'b0);
    collect_a(99, 0, 1'b1, span);
    check("single_span", 32'(span), 32'd4);

    // 12-bit word padded to two frames.
    req_sel = ID; req_mode = 1'b0; req_addr = 5'd0; req_valid_b = 1'b1;
    @(negedge clk);
    req_valid_b = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("b_frame0_valid", {31'd0, fvalid_b}, 32'd1);
    check("b_frame0", frame_b, 32'h0000_00AB);
    @(negedge clk);
    check("b_frame1", frame_b, 32'h0000_00C0);
    @(negedge clk);
    check("b_done", {31'd0, done_b}, 32'd1);
    check("b_done_frame", frame_b, 32'd0);
    @(negedge clk);
    check("b_idle", {31'd0, busy_b}, 32'd0);

    // Full dump, DEPTH=4, data = address.
    for (int i = 0; i < 4; i++) begin
      mem_a[i] = i;
      push_word(i);
    end
    start_a(1'b1, 5'd0, 1'b0);
    collect_a(99, 0, 1'b0, span);
    check("dump_span", 32'(span), 32'd22);
    check("dump_last_addr", {27'd0, addr_a}, 32'd3);

    // Backpressure: frame 1 stalled three cycles.
    mem_a[7] = 32'hCAFE_F00D;
    push_word(32'hCAFE_F00D);
    start_a(1'b0, 5'd7, 1'b0);
    collect_a(1, 3, 1'b0, span);
    check("stall_span", 32'(span), 32'd7);

    // Non-matching select: nothing moves.
    req_sel = 6'b100000; req_mode = 1'b0; req_addr = 5'd5; req_valid_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("badsel_busy", {31'd0, busy_a}, 32'd0);
      check("badsel_valid", {31'd0, fvalid_a}, 32'd0);
      check("badsel_addr", {27'd0, addr_a}, 32'd7);
    end
    req_valid_a = 1'b0;

    // Second request while busy is ignored.
    push_word(32'hDEAD_BEEF);
    start_a(1'b0, 5'd5, 1'b1);
    collect_a(99, 0, 1'b0, span);
    check("busy_req_span", 32'(span), 32'd4);

    // Reset during frame 2 of a dump, then request on the first free cycle.
    mem_a[0] = 32'h0A0B_0C0D;
    start_a(1'b1, 5'd0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("pre_reset_frame2", frame_a, 32'h0000_000C);
    reset = 1'b1;
    @(negedge clk);
    check_reset_state("midreset");
    reset = 1'b0;
    push_word(32'hCAFE_F00D);
    start_a(1'b0, 5'd7, 1'b0);
    collect_a(99, 0, 1'b0, span);
    check("post_reset_span", 32'(span), 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/debug_control_dump.md
DEBUG_CONTROL_DUMP -- requirements
Module: debug_control_dump

Interface
REQ-001 SHALL have parameter NB_LATCH, default 8, meaning payload bits per frame.
REQ-002 SHALL have parameter NB_INPUT_SIZE, default 32, meaning width of source data word.
REQ-003 SHALL have parameter NB_CONTROL_FRAME, default 32, meaning frame bus width, >= NB_LATCH.
REQ-004 SHALL have parameter NB_ADDR, default 5, meaning source address width.
REQ-005 SHALL have parameter DEPTH, default 32, meaning words per full dump, 1..2^NB_ADDR.
REQ-006 SHALL have parameter CONTROLLER_ID, default 6'b000000, meaning request code served.
REQ-007 SHALL have port i_clock  input  1  clock, with reset i_reset, synchronous, active-high; clock i_clock.
REQ-008 SHALL have port i_reset  input  1  synchronous active-high reset.
REQ-009 SHALL have port i_request_valid  input  1  request strobe.
REQ-010 SHALL have port i_request_select  input  6  request code.
REQ-011 SHALL have port i_request_mode  input  1  1 = full dump of 0..DEPTH-1; 0 = single word.
REQ-012 SHALL have port i_request_addr  input  NB_ADDR  word address for single mode.
REQ-013 SHALL have port i_data_from_mips  input  NB_INPUT_SIZE  source data, valid one cycle after o_addr.
REQ-014 SHALL have port i_frame_ready  input  1  interface accepts frame.
REQ-015 SHALL have port o_frame_to_interface  output  NB_CONTROL_FRAME  frame; payload in LSBs, upper bits zero.
REQ-016 SHALL have port o_frame_valid  output  1  frame valid.
REQ-017 SHALL have port o_addr  output  NB_ADDR  source read address.
REQ-018 SHALL have port o_reading  output  1  high while source is being read (ADDR, LATCH).
REQ-019 SHALL have port o_busy  output  1  high in any state except IDLE.
REQ-020 SHALL have port o_done  output  1  one-cycle pulse at end of transfer.

Function
REQ-021 SHALL define N_FRAMES = ceil(NB_INPUT_SIZE/NB_LATCH); word SHALL be padded with zeros at LSB end to N_FRAMES*NB_LATCH bits.
REQ-022 SHALL send frames MSB-first: frame k = padded bits [N_FRAMES*NB_LATCH-1-k*NB_LATCH -: NB_LATCH].
REQ-023 SHALL implement states IDLE, ADDR, LATCH, SEND, DONE, all registered.
REQ-024 IDLE: request accepted when i_request_valid=1 and i_request_select==CONTROLLER_ID; next state ADDR; address register loaded with 0 (mode 1) or i_request_addr (mode 0); mode registered.
REQ-025 Requests with non-matching select, or arriving while o_busy=1, SHALL be ignored with no side effect.
REQ-026 ADDR: one cycle, o_addr drives address register, next LATCH.
REQ-027 LATCH: one cycle, o_addr unchanged, i_data_from_mips captured into shift register at cycle end, frame index cleared, next SEND.
REQ-028 SEND: o_frame_valid=1; frame and valid SHALL stay stable until transfer (o_frame_valid & i_frame_ready at a rising edge).
REQ-029 On transfer of frame index < N_FRAMES-1: index increments, stay SEND; back-to-back transfers SHALL sustain one frame per cycle.
REQ-030 On transfer of last frame: if mode 0 or address == DEPTH-1 then DONE, else address+1 and ADDR.
REQ-031 DONE: o_done=1 for exactly one cycle, o_frame_valid=0, next IDLE; a matching request in DONE SHALL be ignored.
REQ-032 Address counter SHALL never wrap; mode 0 with i_request_addr >= DEPTH SHALL still read that single address.
REQ-033 Latency: accepted request at edge t -> o_addr valid cycle t+1, first o_frame_valid cycle t+3.
REQ-034 o_frame_to_interface SHALL be zero whenever o_frame_valid=0.

Reset
REQ-035 i_reset SHALL take priority over all events, including mid-transfer, and force state IDLE, o_frame_to_interface=0, o_frame_valid=0, o_addr=0, o_reading=0, o_busy=0, o_done=0, frame index 0, shift register 0.
REQ-036 After reset release, a matching request the first cycle SHALL be accepted normally.

Verification
REQ-037 32/8, mode 0, addr 5, data 0xDEADBEEF, ready=1 -> o_addr=5, frames 0xDE,0xAD,0xBE,0xEF on consecutive cycles, then o_done pulse.
REQ-038 NB_INPUT_SIZE=12, NB_LATCH=8, data 0xABC -> frames 0xAB, 0xC0.
REQ-039 DEPTH=4, mode 1, ready=1, data = address -> 16 frames, addresses 0..3 in order, o_done once, o_busy low after.
REQ-040 Backpressure: ready low 3 cycles during frame 1 -> frame 1 held stable, no frame lost or duplicated.
REQ-041 Select 6'b100000 or request while busy -> no state change, no frames.
REQ-042 Reset asserted during frame 2 of a dump -> all outputs zero next cycle; new request completes correctly.
